// File: rtl/kfmmc_card_responder.sv
// Card-side KFMMC CMD-line responder: oversamples mmc_clk, receives and checks 48-bit command
// tokens, hands them to a local controller and transmits its 48-bit response after Ncr.
module kfmmc_card_responder #(
    parameter int unsigned NCR_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mmc_clk,
    input  logic        mmc_cmd_in,
    output logic        mmc_cmd_out,
    output logic        mmc_cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_argument,
    output logic        cmd_error,
    input  logic        resp_valid,
    input  logic        resp_send,
    input  logic [5:0]  resp_index,
    input  logic [31:0] resp_argument,
    input  logic        resp_use_crc,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StRx, StCheck, StWait, StNcr, StTx} state_e;

    localparam logic [6:0] NcrLast = 7'(NCR_CYCLES);

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic data_bit);
        return {crc[5:0], 1'b0} ^ ({7{crc[6] ^ data_bit}} & 7'h09);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] data);
        logic [6:0] crc;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            crc = crc7_step(crc, data[i]);
        end
        return crc;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  clk_sync_q, cmd_sync_q;
    logic        clk_prev_q;
    logic [47:0] rx_shift_q, rx_shift_d;
    logic [6:0]  rx_crc_q, rx_crc_d;
    logic [5:0]  bit_count_q, bit_count_d;
    logic [6:0]  ncr_count_q, ncr_count_d;
    logic [47:0] tx_shift_q, tx_shift_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_argument_q, cmd_argument_d;
    logic        cmd_error_q, cmd_error_d;
    logic        cmd_out_q, cmd_out_d;
    logic        cmd_oe_q, cmd_oe_d;

    logic        clk_s, cmd_s, rise, fall, start_bit;
    logic [39:0] resp_head;

    assign clk_s     = clk_sync_q[1];
    assign cmd_s     = cmd_sync_q[1];
    assign rise      = clk_s & ~clk_prev_q;
    assign fall      = ~clk_s & clk_prev_q;
    assign start_bit = rise & ~cmd_s;
    assign resp_head = {2'b00, resp_index, resp_argument};

    always_comb begin
        state_d        = state_q;
        rx_shift_d     = rx_shift_q;
        rx_crc_d       = rx_crc_q;
        bit_count_d    = bit_count_q;
        ncr_count_d    = ncr_count_q;
        tx_shift_d     = tx_shift_q;
        cmd_valid_d    = cmd_valid_q;
        cmd_index_d    = cmd_index_q;
        cmd_argument_d = cmd_argument_q;
        cmd_error_d    = 1'b0;
        cmd_out_d      = cmd_out_q;
        cmd_oe_d       = cmd_oe_q;

        unique case (state_q)
            StIdle: begin
                if (start_bit) begin
                    rx_shift_d  = '0;
                    rx_crc_d    = '0;
                    bit_count_d = '0;
                    state_d     = StRx;
                end
            end
            StRx: begin
                if (rise) begin
                    rx_shift_d = {rx_shift_q[46:0], cmd_s};
                    // Incoming bit is token bit (bit_count+1); CRC covers token bits 1..39
                    if (bit_count_q <= 6'd38) begin
                        rx_crc_d = crc7_step(rx_crc_q, cmd_s);
                    end
                    if (bit_count_q == 6'd46) begin
                        bit_count_d = 6'd47;
                        state_d     = StCheck;
                    end else begin
                        bit_count_d = bit_count_q + 6'd1;
                    end
                end
            end
            StCheck: begin
                if (!rx_shift_q[47] && rx_shift_q[46] && (rx_shift_q[7:1] == rx_crc_q)
                    && rx_shift_q[0]) begin
                    cmd_valid_d    = 1'b1;
                    cmd_index_d    = rx_shift_q[45:40];
                    cmd_argument_d = rx_shift_q[39:8];
                    state_d        = StWait;
                end else begin
                    cmd_error_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StWait: begin
                // A new start bit from the host takes priority over a same-cycle response
                if (start_bit) begin
                    cmd_valid_d = 1'b0;
                    rx_shift_d  = '0;
                    rx_crc_d    = '0;
                    bit_count_d = '0;
                    state_d     = StRx;
                end else if (resp_valid) begin
                    cmd_valid_d = 1'b0;
                    if (resp_send) begin
                        tx_shift_d  = {resp_head, resp_use_crc ? crc7_40(resp_head) : 7'h7F,
                                       1'b1};
                        ncr_count_d = '0;
                        state_d     = StNcr;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StNcr: begin
                if (fall) begin
                    if (ncr_count_q == NcrLast) begin
                        cmd_oe_d    = 1'b1;
                        cmd_out_d   = tx_shift_q[47];
                        tx_shift_d  = {tx_shift_q[46:0], 1'b1};
                        bit_count_d = '0;
                        state_d     = StTx;
                    end else begin
                        ncr_count_d = ncr_count_q + 7'd1;
                    end
                end
            end
            StTx: begin
                if (fall) begin
                    if (bit_count_q == 6'd47) begin
                        cmd_oe_d  = 1'b0;
                        cmd_out_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        cmd_out_d   = tx_shift_q[47];
                        tx_shift_d  = {tx_shift_q[46:0], 1'b1};
                        bit_count_d = bit_count_q + 6'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            clk_sync_q     <= 2'b11;
            cmd_sync_q     <= 2'b11;
            clk_prev_q     <= 1'b1;
            rx_shift_q     <= '0;
            rx_crc_q       <= '0;
            bit_count_q    <= '0;
            ncr_count_q    <= '0;
            tx_shift_q     <= '1;
            cmd_valid_q    <= 1'b0;
            cmd_index_q    <= '0;
            cmd_argument_q <= '0;
            cmd_error_q    <= 1'b0;
            cmd_out_q      <= 1'b1;
            cmd_oe_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            clk_sync_q     <= {clk_sync_q[0], mmc_clk};
            cmd_sync_q     <= {cmd_sync_q[0], mmc_cmd_in};
            clk_prev_q     <= clk_s;
            rx_shift_q     <= rx_shift_d;
            rx_crc_q       <= rx_crc_d;
            bit_count_q    <= bit_count_d;
            ncr_count_q    <= ncr_count_d;
            tx_shift_q     <= tx_shift_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_index_q    <= cmd_index_d;
            cmd_argument_q <= cmd_argument_d;
            cmd_error_q    <= cmd_error_d;
            cmd_out_q      <= cmd_out_d;
            cmd_oe_q       <= cmd_oe_d;
        end
    end

    assign mmc_cmd_out  = cmd_out_q;
    assign mmc_cmd_oe   = cmd_oe_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_index    = cmd_index_q;
    assign cmd_argument = cmd_argument_q;
    assign cmd_error    = cmd_error_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_kfmmc_card_responder.sv
// Directed bench for kfmmc_card_responder: host-side token driver and response capture,
// 8 system clocks per mmc_clk period.
module tb_kfmmc_card_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mmc_clk = 1'b1;
    logic        host_cmd = 1'b1;
    logic        mmc_cmd_in;
    logic        mmc_cmd_out, mmc_cmd_oe;
    logic        cmd_valid, cmd_error, busy;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_argument;
    logic        resp_valid = 1'b0;
    logic        resp_send = 1'b0;
    logic [5:0]  resp_index = '0;
    logic [31:0] resp_argument = '0;
    logic        resp_use_crc = 1'b0;

    int tests = 0;
    int fails = 0;
    int err_pulses = 0;

    // Open-drain-like CMD line: card drive wins when enabled, otherwise the host value
    assign mmc_cmd_in = mmc_cmd_oe ? mmc_cmd_out : host_cmd;

    kfmmc_card_responder #(.NCR_CYCLES(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .mmc_clk      (mmc_clk),
        .mmc_cmd_in   (mmc_cmd_in),
        .mmc_cmd_out  (mmc_cmd_out),
        .mmc_cmd_oe   (mmc_cmd_oe),
        .cmd_valid    (cmd_valid),
        .cmd_index    (cmd_index),
        .cmd_argument (cmd_argument),
        .cmd_error    (cmd_error),
        .resp_valid   (resp_valid),
        .resp_send    (resp_send),
        .resp_index   (resp_index),
        .resp_argument(resp_argument),
        .resp_use_crc (resp_use_crc),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (cmd_error === 1'b1) err_pulses <= err_pulses + 1;
    end

    // One mmc_clk period starting at a negedge of clock; samples the card drive late in low phase
    task automatic mmc_cycle(input logic b, output logic s_oe, output logic s_out);
        mmc_clk  = 1'b0;
        host_cmd = b;
        repeat (4) @(negedge clock);
        s_oe  = mmc_cmd_oe;
        s_out = mmc_cmd_out;
        mmc_clk = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic send_bits(input logic [47:0] tok, input int hi, input int lo);
        logic o, v;
        for (int i = hi; i >= lo; i--) mmc_cycle(tok[i], o, v);
        host_cmd = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic strobe_resp(input logic send, input logic [5:0] idx, input logic [31:0] arg,
                               input logic use_crc);
        resp_send     = send;
        resp_index    = idx;
        resp_argument = arg;
        resp_use_crc  = use_crc;
        resp_valid    = 1'b1;
        @(negedge clock);
        resp_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic capture_resp(output int idle_falls, output logic [47:0] tok,
                                output logic rel_oe, output logic rel_out);
        logic o, v, started;
        int   nbits;
        idle_falls = 0;
        tok        = '0;
        started    = 1'b0;
        nbits      = 0;
        for (int c = 0; c < 120 && nbits < 48; c++) begin
            mmc_cycle(1'b1, o, v);
            if (started || o) begin
                started = 1'b1;
                tok     = {tok[46:0], (o === 1'b1) ? v : 1'bx};
                nbits++;
            end else begin
                idle_falls++;
            end
        end
        mmc_cycle(1'b1, rel_oe, rel_out);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        tests++; if (mmc_cmd_out !== 1'b1) begin fails++; $display("FAIL reset_out got %b want 1", mmc_cmd_out); end
        tests++; if (mmc_cmd_oe !== 1'b0) begin fails++; $display("FAIL reset_oe got %b want 0", mmc_cmd_oe); end
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", cmd_valid); end
        tests++; if (cmd_index !== 6'd0) begin fails++; $display("FAIL reset_index got %h want 00", cmd_index); end
        tests++; if (cmd_argument !== 32'd0) begin fails++; $display("FAIL reset_arg got %h want 0", cmd_argument); end
        tests++; if (cmd_error !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", cmd_error); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_cmd0();
        int   e0;
        logic o, v, seen_oe;
        e0 = err_pulses;
        send_bits(48'h40_0000_0000_95, 47, 0);
        tests++; if (cmd_valid !== 1'b1) begin fails++; $display("FAIL cmd0_valid got %b want 1", cmd_valid); end
        tests++; if (cmd_index !== 6'd0) begin fails++; $display("FAIL cmd0_index got %h want 00", cmd_index); end
        tests++; if (cmd_argument !== 32'h0) begin fails++; $display("FAIL cmd0_arg got %h want 0", cmd_argument); end
        tests++; if (err_pulses != e0) begin fails++; $display("FAIL cmd0_error got %0d pulses want 0", err_pulses - e0); end
        strobe_resp(1'b0, 6'h00, 32'h0, 1'b1);
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL noresp_valid got %b want 0", cmd_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL noresp_busy got %b want 0", busy); end
        seen_oe = 1'b0;
        for (int c = 0; c < 6; c++) begin
            mmc_cycle(1'b1, o, v);
            if (o !== 1'b0) seen_oe = 1'b1;
        end
        tests++; if (seen_oe) begin fails++; $display("FAIL noresp_oe got 1 want 0"); end
    endtask

    task automatic test_cmd8_r7();
        int          falls;
        logic [47:0] tok;
        logic        ro, rv;
        send_bits(48'h48_0000_01AA_87, 47, 0);
        tests++; if (cmd_valid !== 1'b1) begin fails++; $display("FAIL cmd8_valid got %b want 1", cmd_valid); end
        tests++; if (cmd_index !== 6'd8) begin fails++; $display("FAIL cmd8_index got %h want 08", cmd_index); end
        tests++; if (cmd_argument !== 32'h1AA) begin fails++; $display("FAIL cmd8_arg got %h want 000001aa", cmd_argument); end
        strobe_resp(1'b1, 6'd8, 32'h0000_01AA, 1'b1);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL r7_busy got %b want 1", busy); end
        capture_resp(falls, tok, ro, rv);
        tests++; if (falls != 2) begin fails++; $display("FAIL r7_ncr got %0d falls want 2", falls); end
        tests++; if (tok !== 48'h08_0000_01AA_13) begin fails++; $display("FAIL r7_token got %h want 08000001aa13", tok); end
        tests++; if (ro !== 1'b0) begin fails++; $display("FAIL r7_release_oe got %b want 0", ro); end
        tests++; if (rv !== 1'b1) begin fails++; $display("FAIL r7_release_out got %b want 1", rv); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL r7_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_bad_crc();
        int e0;
        e0 = err_pulses;
        send_bits(48'h40_0000_0000_97, 47, 0);
        tests++; if (err_pulses - e0 != 1) begin fails++; $display("FAIL badcrc_error got %0d pulse clocks want 1", err_pulses - e0); end
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL badcrc_valid got %b want 0", cmd_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL badcrc_busy got %b want 0", busy); end
        tests++; if (cmd_index !== 6'd8) begin fails++; $display("FAIL badcrc_index got %h want 08", cmd_index); end
        tests++; if (cmd_argument !== 32'h1AA) begin fails++; $display("FAIL badcrc_arg got %h want 000001aa", cmd_argument); end
    endtask

    task automatic test_bad_tx_bit();
        int e0;
        e0 = err_pulses;
        send_bits(48'h00_0000_0000_95, 47, 0);
        tests++; if (err_pulses - e0 != 1) begin fails++; $display("FAIL badtx_error got %0d pulse clocks want 1", err_pulses - e0); end
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL badtx_valid got %b want 0", cmd_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL badtx_busy got %b want 0", busy); end
    endtask

    task automatic test_r3();
        int          falls;
        logic [47:0] tok;
        logic        ro, rv;
        send_bits(48'h40_0000_0000_95, 47, 0);
        tests++; if (cmd_valid !== 1'b1) begin fails++; $display("FAIL r3_cmd_valid got %b want 1", cmd_valid); end
        strobe_resp(1'b1, 6'h3F, 32'h80FF_8000, 1'b0);
        capture_resp(falls, tok, ro, rv);
        tests++; if (tok !== 48'h3F_80FF_8000_FF) begin fails++; $display("FAIL r3_token got %h want 3f80ff8000ff", tok); end
        tests++; if (ro !== 1'b0) begin fails++; $display("FAIL r3_release_oe got %b want 0", ro); end
    endtask

    task automatic test_abandon();
        send_bits(48'h48_0000_01AA_87, 47, 0);
        tests++; if (cmd_valid !== 1'b1 || cmd_index !== 6'd8) begin fails++; $display("FAIL abandon_first got valid=%b idx=%h want 1/08", cmd_valid, cmd_index); end
        send_bits(48'h40_0000_0000_95, 47, 47);
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL abandon_drop got %b want 0", cmd_valid); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abandon_busy got %b want 1", busy); end
        send_bits(48'h40_0000_0000_95, 46, 0);
        tests++; if (cmd_valid !== 1'b1) begin fails++; $display("FAIL abandon_revalid got %b want 1", cmd_valid); end
        tests++; if (cmd_index !== 6'd0) begin fails++; $display("FAIL abandon_index got %h want 00", cmd_index); end
    endtask

    task automatic test_reset_mid_tx();
        logic o, v;
        int   nb;
        strobe_resp(1'b1, 6'd0, 32'h0000_0900, 1'b1);
        nb = 0;
        for (int c = 0; c < 20 && nb < 6; c++) begin
            mmc_cycle(1'b1, o, v);
            if (o === 1'b1) nb++;
        end
        mmc_clk = 1'b0;
        repeat (4) @(negedge clock);
        tests++; if (mmc_cmd_oe !== 1'b1) begin fails++; $display("FAIL midtx_pre_oe got %b want 1", mmc_cmd_oe); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (mmc_cmd_oe !== 1'b0) begin fails++; $display("FAIL midtx_oe got %b want 0", mmc_cmd_oe); end
        tests++; if (mmc_cmd_out !== 1'b1) begin fails++; $display("FAIL midtx_out got %b want 1", mmc_cmd_out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midtx_busy got %b want 0", busy); end
        tests++; if (cmd_index !== 6'd0 || cmd_valid !== 1'b0) begin fails++; $display("FAIL midtx_cmd got valid=%b idx=%h want 0/00", cmd_valid, cmd_index); end
        @(negedge clock);
        mmc_clk = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (8) @(negedge clock);
        tests++; if (busy !== 1'b0 || mmc_cmd_oe !== 1'b0) begin fails++; $display("FAIL midtx_after got busy=%b oe=%b want 0/0", busy, mmc_cmd_oe); end
    endtask

    task automatic test_resp_outside_wait();
        logic o, v, seen;
        strobe_resp(1'b1, 6'h11, 32'h1234_5678, 1'b1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_resp_busy got %b want 0", busy); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            mmc_cycle(1'b1, o, v);
            if (o !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen) begin fails++; $display("FAIL idle_resp_oe got 1 want 0"); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_cmd0();
        test_cmd8_r7();
        test_bad_crc();
        test_bad_tx_bit();
        test_r3();
        test_abandon();
        test_reset_mid_tx();
        test_resp_outside_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
